status_drive_arb: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared status/drive datapath: the 14-bit status register and the enable/debug drive-select lines that choose the `out_i` source. Each requester asks for ownership with a level `req`, receives a grant, has its status word and drive mode loaded, holds the drive for a programmable number of cycles, and is released with a one-cycle `done`. The block sits between the host and debug command sources and the status/drive datapath, and is the only writer of that register and those lines.

---
 rtl/status_drive_arb.sv | 164 ++++++++++++++++
 tb/tb_status_drive_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/status_drive_arb.sv
// ============================================================================
// Module  : status_drive_arb
// Brief   : Two-requester round-robin arbiter/sequencer for status/drive path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module status_drive_arb #(
  parameter int DW   = 14,
  parameter int HOLD = 4
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [1:0]    mode0,
  input  logic [1:0]    mode1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          abort_o,
  output logic          err_o,
  output logic [DW-1:0] foo_q,
  output logic          enable,
  output logic          debug,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_gnt  = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;
  localparam logic [1:0] c_st_done = 2'd3;

  localparam logic [7:0] c_hold_load = 8'(HOLD - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          abort_q, abort_d;
  logic          err_q, err_d;
  logic [DW-1:0] foo_d;
  logic          enable_q, enable_d;
  logic          debug_q, debug_d;
  logic          busy_q, busy_d;
  logic          owner_q, owner_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          w_own_req;
  logic          w_pick;
  logic [1:0]    w_own_mode;

  // owner_q tracks the current grantee from the grant edge onwards
  assign w_own_req  = owner_q ? req1 : req0;
  assign w_own_mode = owner_q ? mode1 : mode0;
  assign w_pick     = (req0 && req1) ? ~owner_q : req1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    abort_d  = 1'b0;
    err_d    = err_q;
    foo_d    = foo_q;
    enable_d = enable_q;
    debug_d  = debug_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;

    case (state_q)
      c_st_idle: begin
        if (req0 || req1) begin
          gnt_d   = w_pick ? 2'b10 : 2'b01;
          owner_d = w_pick;
          state_d = c_st_gnt;
        end
      end
      c_st_gnt: begin
        if (!w_own_req) begin
          state_d  = c_st_idle;
          gnt_d    = 2'b00;
          enable_d = 1'b0;
          debug_d  = 1'b0;
          abort_d  = 1'b1;
        end else begin
          foo_d    = owner_q ? data1 : data0;
          enable_d = (w_own_mode == 2'b01);
          debug_d  = (w_own_mode == 2'b10);
          if (w_own_mode == 2'b11) err_d = 1'b1;
          cnt_d    = c_hold_load;
          state_d  = c_st_hold;
        end
      end
      c_st_hold: begin
        // An early drop wins over a same-cycle terminal count
        if (!w_own_req) begin
          state_d  = c_st_idle;
          gnt_d    = 2'b00;
          enable_d = 1'b0;
          debug_d  = 1'b0;
          abort_d  = 1'b1;
        end else if (cnt_q == 8'd0) begin
          state_d  = c_st_done;
          gnt_d    = 2'b00;
          done_d   = owner_q ? 2'b10 : 2'b01;
          enable_d = 1'b0;
          debug_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    busy_d = (state_d != c_st_idle);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= c_st_idle;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      foo_q    <= '0;
      enable_q <= 1'b0;
      debug_q  <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= 1'b1;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      foo_q    <= foo_d;
      enable_q <= enable_d;
      debug_q  <= debug_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign done0   = done_q[0];
  assign done1   = done_q[1];
  assign abort_o = abort_q;
  assign err_o   = err_q;
  assign enable  = enable_q;
  assign debug   = debug_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_status_drive_arb.sv
// ============================================================================
// Module  : tb_status_drive_arb
// Brief   : Directed self-checking bench for status_drive_arb (HOLD=4 and 1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_status_drive_arb;

  localparam int DW = 14;

  logic          sysclk;
  logic          reset;
  logic          req0, req1;
  logic [DW-1:0] data0, data1;
  logic [1:0]    mode0, mode1;
  logic          gnt0, gnt1, done0, done1, abort_o, err_o;
  logic [DW-1:0] foo_q;
  logic          enable, debug, busy, owner;

  logic          h_req0, h_req1;
  logic [DW-1:0] h_data0, h_data1;
  logic [1:0]    h_mode0, h_mode1;
  logic          h_gnt0, h_gnt1, h_done0, h_done1, h_abort, h_err;
  logic [DW-1:0] h_foo;
  logic          h_enable, h_debug, h_busy, h_owner;

  int n_checks;
  int n_fail;

  status_drive_arb #(.DW(DW), .HOLD(4)) dut (
    .sysclk(sysclk), .reset(reset),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .mode0(mode0), .mode1(mode1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .abort_o(abort_o), .err_o(err_o), .foo_q(foo_q),
    .enable(enable), .debug(debug), .busy(busy), .owner(owner)
  );

  status_drive_arb #(.DW(DW), .HOLD(1)) dut_h1 (
    .sysclk(sysclk), .reset(reset),
    .req0(h_req0), .req1(h_req1), .data0(h_data0), .data1(h_data1),
    .mode0(h_mode0), .mode1(h_mode1),
    .gnt0(h_gnt0), .gnt1(h_gnt1), .done0(h_done0), .done1(h_done1),
    .abort_o(h_abort), .err_o(h_err), .foo_q(h_foo),
    .enable(h_enable), .debug(h_debug), .busy(h_busy), .owner(h_owner)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe just after the active edge; inputs set here reach the next edge
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    req0 = 0; req1 = 0; data0 = '0; data1 = '0; mode0 = 2'b00; mode1 = 2'b00;
    h_req0 = 0; h_req1 = 0; h_data0 = '0; h_data1 = '0; h_mode0 = 2'b00; h_mode1 = 2'b00;

    // Reset values
    tick();
    check("rst_state", 32'({gnt1, gnt0, done1, done0, abort_o, err_o, enable, debug, busy}), 0);
    check("rst_owner", 32'(owner), 1);
    check("rst_foo",   32'(foo_q), 0);
    reset = 1'b1;
    tick();

    // Tie fairness from reset: 0,1,0,1
    req0 = 1; req1 = 1;
    data0 = 14'h0111; data1 = 14'h0222; mode0 = 2'b01; mode1 = 2'b10;
    for (int i = 0; i < 4; i++) begin
      int t;
      logic [1:0] g;
      logic [1:0] exp_g;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      t = 0;
      do begin tick(); t++; end while (!(gnt0 || gnt1) && t < 12);
      g = {gnt1, gnt0};
      check("tie_gnt", 32'(g), 32'(exp_g));
      t = 0;
      do begin
        tick(); t++;
        check("tie_onehot", 32'(gnt0 & gnt1), 0);
      end while (!(done0 || done1) && t < 12);
      check("tie_done", 32'({done1, done0}), 32'(exp_g));
      if (i == 3) begin req0 = 0; req1 = 0; end
    end
    tick();
    check("tie_idle", 32'(busy), 0);

    // Single request, HOLD=4, req1 raised mid-transaction and dropped before idle
    req0 = 1; data0 = 14'h02A5; mode0 = 2'b01;
    tick();
    check("single_gnt", 32'({gnt1, gnt0, busy}), 32'b011);
    check("single_owner", 32'(owner), 0);
    req1 = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("single_foo", 32'(foo_q), 32'h02A5);
      check("single_drive", 32'({enable, debug, gnt1, done0}), 32'b1000);
    end
    req1 = 0;
    tick();
    check("single_done", 32'({done0, done1, gnt0, enable, busy}), 32'b10001);
    req0 = 0;
    tick();
    check("single_end", 32'({done0, busy, gnt1}), 0);

    // Debug mode on requester 1
    req1 = 1; data1 = 14'h0155; mode1 = 2'b10;
    tick();
    check("dbg_gnt", 32'({gnt1, gnt0}), 32'b10);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("dbg_drive", 32'({debug, enable}), 32'b10);
    end
    check("dbg_foo", 32'(foo_q), 32'h0155);
    tick();
    check("dbg_done", 32'({done1, debug}), 32'b10);
    req1 = 0;
    tick();

    // Illegal mode: behaves as value path, sets sticky error
    req0 = 1; data0 = 14'h3FFF; mode0 = 2'b11;
    tick();
    check("ill_gnt", 32'(gnt0), 1);
    tick();
    check("ill_drive", 32'({enable, debug}), 0);
    check("ill_err", 32'(err_o), 1);
    check("ill_foo", 32'(foo_q), 32'h3FFF);
    for (int c = 0; c < 4; c++) tick();
    check("ill_done", 32'(done0), 1);
    req0 = 0;
    tick();
    tick();
    check("ill_err_sticky", 32'({err_o, busy}), 32'b10);

    // Abort in HOLD with req1 pending
    req0 = 1; data0 = 14'h00AB; mode0 = 2'b01;
    tick();
    check("abt_gnt", 32'(gnt0), 1);
    tick();
    check("abt_drive", 32'({enable, foo_q}), 32'({1'b1, 14'h00AB}));
    req1 = 1; data1 = 14'h0CDE; mode1 = 2'b10;
    tick();
    req0 = 0;
    tick();
    check("abt_pulse", 32'({abort_o, gnt0, enable, done0, busy}), 32'b10000);
    check("abt_foo", 32'(foo_q), 32'h00AB);
    tick();
    check("abt_next_gnt", 32'({gnt1, abort_o}), 32'b10);

    // Asynchronous reset in HOLD
    tick();
    check("rstm_pre", 32'({debug, gnt1}), 32'b11);
    reset = 1'b0;
    #1;
    check("rstm_outs", 32'({gnt1, gnt0, done1, done0, abort_o, err_o, enable, debug, busy}), 0);
    check("rstm_foo", 32'(foo_q), 0);
    check("rstm_owner", 32'(owner), 1);
    tick();
    reset = 1'b1;
    req0 = 1; req1 = 1; data0 = 14'h0777;
    tick();
    check("rstm_tie", 32'({gnt1, gnt0}), 32'b01);
    req0 = 0; req1 = 0;
    tick();
    check("gnt_abort", 32'({abort_o, gnt0, busy}), 32'b100);
    check("gnt_abort_foo", 32'(foo_q), 0);

    // HOLD=1 boundary with back-to-back request
    h_req0 = 1; h_data0 = 14'h1234; h_mode0 = 2'b10;
    tick();
    check("h1_gnt", 32'(h_gnt0), 1);
    tick();
    check("h1_drive", 32'({h_debug, h_enable, h_foo}), 32'({2'b10, 14'h1234}));
    tick();
    check("h1_done", 32'({h_done0, h_debug, h_gnt0}), 32'b100);
    tick();
    check("h1_idle", 32'({h_done0, h_gnt0, h_busy}), 0);
    tick();
    check("h1_b2b_gnt", 32'(h_gnt0), 1);
    h_req0 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
